morph_window_gen: RTL
=====================

// Module: morph_window_gen
// PURPOSE
//  Upstream stage of the multiscale morphology datapath. Accepts a raster pixel stream
//  (one pixel per beat, row-major, single frame of IMG_W x IMG_H) and emits a 3x3
//  neighbourhood window per pixel. Two internal line buffers hold the window rows.
//  Out-of-image taps are replaced by BORDER_VAL. One window is produced per input pixel;
//  these windows feed the erosion/dilation kernels of morph_top_multiscale.
// PARAMETERS
//  IMG_W       256  pixels per line (>=2)
//  IMG_H       256  lines per frame (>=2)
//  DW          8    pixel width in bits
//  BORDER_VAL  0    pad value for out-of-image taps (0 for dilation, 2^DW-1 for erosion)
// PORTS
//  clk         in   1      single clock, all logic rising-edge
//  rst         in   1      asynchronous, active-high reset
//  in_valid    in   1      pixel_in carries a valid beat
//  pixel_in    in   DW     raster pixel
//  in_ready    out  1      beat accepted when in_valid & in_ready
//  win_valid   out  1      win_out/win_x/win_y valid this cycle
//  win_out     out  9*DW   tap k at [k*DW +: DW], k=3*r+c; r=0 top row, c=0 left column; k=4 centre
//  win_x       out  clog2(IMG_W)  centre column
//  win_y       out  clog2(IMG_H)  centre row
//  frame_done  out  1      1-cycle pulse coincident with last window of frame (centre IMG_W-1,IMG_H-1)
// BEHAVIOUR
//  - Reset (async, asserted): all outputs 0, in_ready=0 while rst high, counters 0, state FILL.
//    Line-buffer RAM contents are not reset; stale data is never visible because taps are masked.
//    Reset mid-frame discards the partial frame. The first beat after release is pixel (0,0).
//  - Beat index n = y_in*IMG_W + x_in. A beat with n >= IMG_W+1 completes the window
//    centred at n-(IMG_W+1). The window is registered, so win_valid is high on the cycle after
//    that beat. Latency = IMG_W+1 beats + 1 clock.
//  - FSM:
//    - FILL: in_ready=1. Counts the first IMG_W+1 accepted beats; no output.
//      Then -> RUN.
//    - RUN: in_ready=1. Every accepted beat emits one window. On the beat with n = IMG_W*IMG_H-1
//      -> FLUSH.
//    - FLUSH: in_ready=0; in_valid is ignored. Generates IMG_W+1 internal beats, one per clock,
//      with pixel=BORDER_VAL, each emitting one window. After the last one -> FILL, counters cleared.
//  - Bubbles (in_valid=0 in FILL/RUN): no state advance, win_valid=0 next cycle,
//    and win_out holds its value.
//  - Exactly IMG_W*IMG_H windows per frame, in raster order of centre.
//  - Masking: left column (c=0) forced to BORDER_VAL when win_x==0; right column (c=2) when
//    win_x==IMG_W-1 (covers line wrap); top row when win_y==0; bottom row when win_y==IMG_H-1.
//    Corners are covered by the OR of these conditions.
//  - Line buffers: lb1 holds row y-2, lb0 holds row y-1, both addressed by x_in. Each cycle does
//    one read and one write at the same address. Read returns old data (read-before-write).
//    On a beat: lb1[x] <= lb0[x], lb0[x] <= pixel. New column = {lb1[x], lb0[x], pixel}.
//    It is shifted into a 3x3 register array.
//  - Counters wrap: x_in IMG_W-1 -> 0 with y_in increment. y_in wraps to 0 at frame end.
//    No arithmetic beyond counter compares; no width growth.
// STRUCTURE
//  - morph_pkg: DW, BORDER_VAL defaults, tap index localparams (TAP_NW..TAP_SE, TAP_C=4),
//    and FSM state encoding (FILL, RUN, FLUSH).
//  - Sub-module morph_linebuf: DEPTH=IMG_W, width DW, 1R1W same-address, read-before-write,
//    registered read aligned to the 3x3 shift. Two instances.
//  - Top level: FSM, x/y counters, 3x3 tap registers, border mask, output registers.
// TESTING (IMG_W=4, IMG_H=4 unless noted; input pixel = 4*y+x)
//  1. Hold rst, drive in_valid=1: in_ready=0, win_valid=0, win_out=0, frame_done=0.
//     Assert rst asynchronously mid-clock: outputs clear without a clock edge.
//  2. Stream 16 beats, BORDER_VAL=0: first win_valid on the cycle after beat 6 (n=5).
//     Centre (0,0), win_out taps = [0,0,0, 0,0,1, 0,4,5].
//     Centre (1,1) = [0,1,2, 4,5,6, 8,9,10].
//  3. Flush: after beat 16, in_ready=0 for exactly 5 cycles.
//     Last window centre (3,3) = [10,11,B, 14,15,B, B,B,B] with frame_done=1.
//     Total win_valid count = 16.
//  4. Same frame with random in_valid bubbles: window sequence identical to scenario 2/3.
//     win_out holds during bubbles.
//  5. Assert rst after beat 9, then stream a fresh frame:
//     output is identical to scenario 2/3 (no stale-row leakage).
//  6. IMG_W=IMG_H=256, BORDER_VAL=255, random image back-to-back over two frames:
//     65536 windows per frame and frame_done twice.
//     Every window must match a software 3x3 reference with 255 padding.

Source files
------------

// File: rtl/morph_pkg.sv
`default_nettype none
// ============================================================================
// morph_pkg : shared defaults, 3x3 tap indices and window-generator FSM states
// Revision  : 1.0
// ============================================================================
package morph_pkg;

    localparam int DW_DEF     = 8;
    localparam int BORDER_DEF = 0;

    // Tap k = 3*row + col, row 0 on top, col 0 on the left.
    localparam int TAP_NW   = 0;
    localparam int TAP_N    = 1;
    localparam int TAP_NE   = 2;
    localparam int TAP_W    = 3;
    localparam int TAP_C    = 4;
    localparam int TAP_E    = 5;
    localparam int TAP_SW   = 6;
    localparam int TAP_S    = 7;
    localparam int TAP_SE   = 8;
    localparam int NUM_TAPS = 9;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

endpackage
`default_nettype wire

// File: rtl/morph_linebuf.sv
`default_nettype none
// ============================================================================
// morph_linebuf : one raster line store, 1R1W at one address, read-before-write
// Revision      : 1.0
// ============================================================================
module morph_linebuf #(
    parameter int DEPTH = 256,
    parameter int DW    = 8,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          wr_en_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];

    // Old contents are presented during the write cycle; the caller's tap
    // registers capture them on the same edge that commits the write.
    assign rdata_o = mem_q[addr_i];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/morph_window_gen.sv
`default_nettype none
// ============================================================================
// morph_window_gen : raster stream to bordered 3x3 window per pixel
// Revision         : 1.0
// ============================================================================
module morph_window_gen
    import morph_pkg::*;
#(
    parameter int  IMG_W      = 256,
    parameter int  IMG_H      = 256,
    parameter int  DW         = DW_DEF,
    parameter int  BORDER_VAL = BORDER_DEF,
    localparam int XW         = (IMG_W > 1) ? $clog2(IMG_W) : 1,
    localparam int YW         = (IMG_H > 1) ? $clog2(IMG_H) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [DW-1:0]   pixel_in,
    output logic            in_ready,
    output logic            win_valid,
    output logic [9*DW-1:0] win_out,
    output logic [XW-1:0]   win_x,
    output logic [YW-1:0]   win_y,
    output logic            frame_done
);

    localparam logic [DW-1:0] BORDER = DW'(BORDER_VAL);
    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

    state_e          state_q, state_d;
    logic [XW-1:0]   x_in_q, x_in_d, x_out_q, x_out_d;
    logic [YW-1:0]   y_in_q, y_in_d, y_out_q, y_out_d;
    logic            ready_q, ready_d;
    logic [DW-1:0]   col0_q [3];
    logic [DW-1:0]   col1_q [3];
    logic            win_valid_q, frame_done_q;
    logic [9*DW-1:0] win_out_q;
    logic [XW-1:0]   win_x_q;
    logic [YW-1:0]   win_y_q;

    logic            w_accept, w_beat, w_emit, w_last_out;
    logic [DW-1:0]   w_pix, w_lb0_rd, w_lb1_rd;
    logic [DW-1:0]   w_taps [NUM_TAPS];
    logic [9*DW-1:0] w_win;

    assign w_accept   = in_valid && ready_q;
    assign w_beat     = w_accept || (state_q == ST_FLUSH);
    assign w_emit     = (w_accept && (state_q == ST_RUN)) || (state_q == ST_FLUSH);
    assign w_pix      = (state_q == ST_FLUSH) ? BORDER : pixel_in;
    assign w_last_out = (x_out_q == X_LAST) && (y_out_q == Y_LAST);

    morph_linebuf #(.DEPTH(IMG_W), .DW(DW), .AW(XW)) u_lb0 (
        .clk     (clk),
        .wr_en_i (w_beat),
        .addr_i  (x_in_q),
        .wdata_i (w_pix),
        .rdata_o (w_lb0_rd)
    );

    morph_linebuf #(.DEPTH(IMG_W), .DW(DW), .AW(XW)) u_lb1 (
        .clk     (clk),
        .wr_en_i (w_beat),
        .addr_i  (x_in_q),
        .wdata_i (w_lb0_rd),
        .rdata_o (w_lb1_rd)
    );

    // Right column is the incoming column; masking by centre position also
    // hides stale line-buffer rows and the wrap onto the next line.
    always_comb begin
        w_taps[TAP_NW] = col0_q[0];
        w_taps[TAP_W]  = col0_q[1];
        w_taps[TAP_SW] = col0_q[2];
        w_taps[TAP_N]  = col1_q[0];
        w_taps[TAP_C]  = col1_q[1];
        w_taps[TAP_S]  = col1_q[2];
        w_taps[TAP_NE] = w_lb1_rd;
        w_taps[TAP_E]  = w_lb0_rd;
        w_taps[TAP_SE] = w_pix;
        if (x_out_q == '0) begin
            w_taps[TAP_NW] = BORDER;
            w_taps[TAP_W]  = BORDER;
            w_taps[TAP_SW] = BORDER;
        end
        if (x_out_q == X_LAST) begin
            w_taps[TAP_NE] = BORDER;
            w_taps[TAP_E]  = BORDER;
            w_taps[TAP_SE] = BORDER;
        end
        if (y_out_q == '0) begin
            w_taps[TAP_NW] = BORDER;
            w_taps[TAP_N]  = BORDER;
            w_taps[TAP_NE] = BORDER;
        end
        if (y_out_q == Y_LAST) begin
            w_taps[TAP_SW] = BORDER;
            w_taps[TAP_S]  = BORDER;
            w_taps[TAP_SE] = BORDER;
        end
        w_win = '0;
        for (int k = 0; k < NUM_TAPS; k++) begin
            w_win[k*DW +: DW] = w_taps[k];
        end
    end

    always_comb begin
        state_d = state_q;
        x_in_d  = x_in_q;
        y_in_d  = y_in_q;
        x_out_d = x_out_q;
        y_out_d = y_out_q;
        if (w_beat) begin
            x_in_d = (x_in_q == X_LAST) ? '0 : x_in_q + XW'(1);
            if (x_in_q == X_LAST) begin
                y_in_d = (y_in_q == Y_LAST) ? '0 : y_in_q + YW'(1);
            end
        end
        if (w_emit) begin
            x_out_d = (x_out_q == X_LAST) ? '0 : x_out_q + XW'(1);
            if (x_out_q == X_LAST) begin
                y_out_d = (y_out_q == Y_LAST) ? '0 : y_out_q + YW'(1);
            end
        end
        case (state_q)
            ST_FILL: begin
                // Beat n = IMG_W is the last one needed before windows can form.
                if (w_accept && (x_in_q == '0) && (y_in_q == YW'(1))) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_accept && (x_in_q == X_LAST) && (y_in_q == Y_LAST)) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (w_last_out) begin
                    state_d = ST_FILL;
                    x_in_d  = '0;
                    y_in_d  = '0;
                    x_out_d = '0;
                    y_out_d = '0;
                end
            end
            default: begin
                state_d = ST_FILL;
            end
        endcase
        ready_d = (state_d != ST_FLUSH);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_FILL;
            x_in_q       <= '0;
            y_in_q       <= '0;
            x_out_q      <= '0;
            y_out_q      <= '0;
            ready_q      <= 1'b0;
            win_valid_q  <= 1'b0;
            win_out_q    <= '0;
            win_x_q      <= '0;
            win_y_q      <= '0;
            frame_done_q <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                col0_q[i] <= '0;
                col1_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            x_in_q       <= x_in_d;
            y_in_q       <= y_in_d;
            x_out_q      <= x_out_d;
            y_out_q      <= y_out_d;
            ready_q      <= ready_d;
            win_valid_q  <= w_emit;
            frame_done_q <= w_emit && w_last_out;
            if (w_beat) begin
                for (int i = 0; i < 3; i++) begin
                    col0_q[i] <= col1_q[i];
                end
                col1_q[0] <= w_lb1_rd;
                col1_q[1] <= w_lb0_rd;
                col1_q[2] <= w_pix;
            end
            if (w_emit) begin
                win_out_q <= w_win;
                win_x_q   <= x_out_q;
                win_y_q   <= y_out_q;
            end
        end
    end

    assign in_ready   = ready_q;
    assign win_valid  = win_valid_q;
    assign win_out    = win_out_q;
    assign win_x      = win_x_q;
    assign win_y      = win_y_q;
    assign frame_done = frame_done_q;

endmodule
`default_nettype wire
